// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: recovers x/y from hsync/vsync, tracks lock, flags bad line/frame lengths.
// Define COLOR_HIST_EN to build the per-frame R/G/B pixel counters; otherwise they read as zero.
module vga_sync_monitor #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  rgbtext,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [2:0]  rgb_out,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        err_hlen,
    output logic        err_vlen,
    output logic [15:0] frame_count,
    output logic [18:0] red_cnt,
    output logic [18:0] grn_cnt,
    output logic [18:0] blu_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_STOP  = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_STOP  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [9:0] CNT_MAX = 10'd1023;
    localparam logic [9:0] CNT_PRE = 10'd1022;

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] ALIGN  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    logic       hs_p0, vs_p0;
    logic [9:0] h_cnt, v_cnt;
    logic       h_seen;
    logic [1:0] state;
    logic [7:0] good_frames;

    logic       h_fall, v_fall, tracking, err_h, err_v, in_win, frame_inc;
    logic [9:0] h_nxt, v_nxt;
    logic [1:0] state_nxt;
    logic [7:0] good_nxt;

    assign h_fall   = pix_en & hs_p0 & ~hsync;
    assign v_fall   = pix_en & vs_p0 & ~vsync;
    assign tracking = (state == ALIGN) || (state == LOCKED);
    // The first line after a restart has no trusted start point, so h_seen gates its check.
    assign err_h    = pix_en & ((h_fall & h_seen & (h_cnt != H_LAST)) |
                                (tracking & ~h_fall & (h_cnt == CNT_PRE)));
    assign err_v    = v_fall & tracking & (v_cnt != V_LAST);

    always_comb begin
        h_nxt = h_cnt;
        if (h_fall)
            h_nxt = '0;
        else if (h_cnt != CNT_MAX)
            h_nxt = h_cnt + 10'd1;
        v_nxt = v_cnt;
        if (v_fall)
            v_nxt = '0;
        else if (h_fall && (v_cnt != CNT_MAX))
            v_nxt = v_cnt + 10'd1;
    end

    assign in_win = (h_nxt >= H_START) && (h_nxt <= H_STOP) &&
                    (v_nxt >= V_START) && (v_nxt <= V_STOP);

    always_comb begin
        state_nxt = state;
        good_nxt  = good_frames;
        frame_inc = 1'b0;
        case (state)
            SEARCH: begin
                if (v_fall && !err_h) begin
                    state_nxt = ALIGN;
                    good_nxt  = '0;
                end
            end
            ALIGN: begin
                if (err_h || err_v) begin
                    state_nxt = SEARCH;
                end else if (v_fall) begin
                    good_nxt = good_frames + 8'd1;
                    if (good_nxt == 8'(LOCK_FRAMES))
                        state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (err_h || err_v)
                    state_nxt = SEARCH;
                else if (v_fall)
                    frame_inc = 1'b1;
            end
            default: state_nxt = SEARCH;
        endcase
    end

    // Pixel stage: sync history, counters and FSM advance; x/y/rgb reflect the sample just taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_p0       <= 1'b1;
            vs_p0       <= 1'b1;
            h_cnt       <= '0;
            v_cnt       <= '0;
            h_seen      <= 1'b0;
            state       <= SEARCH;
            good_frames <= '0;
            frame_count <= '0;
            locked      <= 1'b0;
            err_hlen    <= 1'b0;
            err_vlen    <= 1'b0;
            frame_start <= 1'b0;
            x           <= '0;
            y           <= '0;
            rgb_out     <= '0;
            pixel_valid <= 1'b0;
        end else begin
            err_hlen    <= err_h;
            err_vlen    <= err_v;
            frame_start <= v_fall;
            locked      <= (state == LOCKED);
            if (pix_en) begin
                hs_p0       <= hsync;
                vs_p0       <= vsync;
                h_cnt       <= h_nxt;
                v_cnt       <= v_nxt;
                state       <= state_nxt;
                good_frames <= good_nxt;
                if (frame_inc)
                    frame_count <= frame_count + 16'd1;
                if (err_h || err_v)
                    h_seen <= 1'b0;
                else if (h_fall)
                    h_seen <= 1'b1;
                pixel_valid <= in_win & tracking;
                x           <= in_win ? (h_nxt - H_START) : '0;
                y           <= in_win ? (v_nxt - V_START) : '0;
                rgb_out     <= rgbtext;
            end
        end
    end

`ifdef COLOR_HIST_EN
    logic [18:0] red_acc, grn_acc, blu_acc;
    logic        hist_armed;

    // The first vsync edge only starts a frame; publishing begins from the second one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            red_acc    <= '0;
            grn_acc    <= '0;
            blu_acc    <= '0;
            hist_armed <= 1'b0;
            red_cnt    <= '0;
            grn_cnt    <= '0;
            blu_cnt    <= '0;
        end else if (pix_en) begin
            if (v_fall) begin
                if (hist_armed) begin
                    red_cnt <= red_acc;
                    grn_cnt <= grn_acc;
                    blu_cnt <= blu_acc;
                end
                hist_armed <= 1'b1;
                red_acc    <= '0;
                grn_acc    <= '0;
                blu_acc    <= '0;
            end else if (in_win) begin
                red_acc <= red_acc + 19'(rgbtext[2]);
                grn_acc <= grn_acc + 19'(rgbtext[1]);
                blu_acc <= blu_acc + 19'(rgbtext[0]);
            end
        end
    end
`else
    assign red_cnt = '0;
    assign grn_cnt = '0;
    assign blu_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a shrunken timing (25x15) so whole frames stay short.
module tb_vga_sync_monitor;
    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FULL = HA * VA;
`ifdef COLOR_HIST_EN
    localparam bit HIST_ON = 1'b1;
`else
    localparam bit HIST_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en, hsync, vsync;
    logic [2:0]  rgbtext;
    logic [9:0]  x, y;
    logic [2:0]  rgb_out;
    logic        pixel_valid, frame_start, locked, err_hlen, err_vlen;
    logic [15:0] frame_count;
    logic [18:0] red_cnt, grn_cnt, blu_cnt;

    always #10 clk = ~clk;

    vga_sync_monitor #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .rgbtext(rgbtext), .x(x), .y(y), .rgb_out(rgb_out), .pixel_valid(pixel_valid),
        .frame_start(frame_start), .locked(locked), .err_hlen(err_hlen), .err_vlen(err_vlen),
        .frame_count(frame_count), .red_cnt(red_cnt), .grn_cnt(grn_cnt), .blu_cnt(blu_cnt)
    );

    typedef struct {
        int         lines;
        int         short_line;
        logic [2:0] rgb;
        int         errh;
        int         errv;
        logic       lock;
        int         fc;
        int         red;
        int         grn;
        int         blu;
    } vec_t;

    vec_t tbl[17];
    int n_tests = 0, n_fail = 0;
    int n_errh, n_errv, n_fs, n_wide;

    // Capture points (h, v) and the x/y/pixel_valid expected there.
    int cap_h[6]  = '{HS+HB,    HS+HB+HA-1, HS+HB+HA, HS+HB-1, HS+HB,      HS+HB};
    int cap_v[6]  = '{VS+VB,    VS+VB,      VS+VB,    VS+VB,   VS+VB+VA-1, VS+VB+VA};
    int exp_x[6]  = '{0,        HA-1,       0,        0,       0,          0};
    int exp_y[6]  = '{0,        0,          0,        0,       VA-1,       0};
    int exp_pv[6] = '{1,        1,          0,        0,       1,          0};
    logic [9:0] got_x[6], got_y[6];
    logic       got_pv[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pix(input int h, input int v, input logic hs, input logic vs, input logic [2:0] rgb);
        @(negedge clk);
        if (err_hlen || err_vlen || frame_start) n_wide++;
        pix_en = 1'b1; hsync = hs; vsync = vs; rgbtext = rgb;
        @(negedge clk);
        if (err_hlen) n_errh++;
        if (err_vlen) n_errv++;
        if (frame_start) n_fs++;
        for (int k = 0; k < 6; k++)
            if (h == cap_h[k] && v == cap_v[k]) begin
                got_x[k] = x; got_y[k] = y; got_pv[k] = pixel_valid;
            end
        pix_en = 1'b0;
    endtask

    task automatic run_lines(input int first, input int last, input int short_line, input logic [2:0] rgb);
        int len;
        for (int v = first; v <= last; v++) begin
            len = (v == short_line) ? HT - 1 : HT;
            for (int h = 0; h < len; h++)
                pix(h, v, (h >= HS), (v >= VS), rgb);
        end
    endtask

    initial begin
        //         lines   short rgb     errh errv lock fc  red   grn   blu
        tbl[0]  = '{VT,     -1, 3'b000, 0, 0, 1'b0, 0, 0,    0,    0};
        tbl[1]  = '{VT,     -1, 3'b000, 0, 0, 1'b0, 0, 0,    0,    0};
        tbl[2]  = '{VT,     -1, 3'b000, 0, 0, 1'b1, 0, 0,    0,    0};
        tbl[3]  = '{VT,     -1, 3'b100, 0, 0, 1'b1, 1, 0,    0,    0};
        tbl[4]  = '{VT,     -1, 3'b010, 0, 0, 1'b1, 2, FULL, 0,    0};
        tbl[5]  = '{VT,     -1, 3'b001, 0, 0, 1'b1, 3, 0,    FULL, 0};
        tbl[6]  = '{VT,      6, 3'b000, 1, 0, 1'b0, 4, 0,    0,    FULL};
        tbl[7]  = '{VT,     -1, 3'b000, 0, 0, 1'b0, 4, 0,    0,    0};
        tbl[8]  = '{VT,     -1, 3'b000, 0, 0, 1'b0, 4, 0,    0,    0};
        tbl[9]  = '{VT,     -1, 3'b000, 0, 0, 1'b1, 4, 0,    0,    0};
        tbl[10] = '{VT,     -1, 3'b000, 0, 0, 1'b1, 5, 0,    0,    0};
        tbl[11] = '{VT - 1, -1, 3'b000, 0, 0, 1'b1, 6, 0,    0,    0};
        tbl[12] = '{VT,     -1, 3'b000, 0, 1, 1'b0, 6, 0,    0,    0};
        tbl[13] = '{VT,     -1, 3'b000, 0, 0, 1'b0, 6, 0,    0,    0};
        tbl[14] = '{VT,     -1, 3'b000, 0, 0, 1'b0, 6, 0,    0,    0};
        tbl[15] = '{VT,     -1, 3'b000, 0, 0, 1'b1, 6, 0,    0,    0};
        tbl[16] = '{VT,     -1, 3'b000, 0, 0, 1'b1, 7, 0,    0,    0};

        n_wide = 0;
        reset = 1'b0; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; rgbtext = 3'b000;
        #40 reset = 1'b1;
        @(negedge clk);
        check("reset_state", {x, y, rgb_out, pixel_valid, frame_start, locked, err_hlen, err_vlen,
                              frame_count, red_cnt, grn_cnt, blu_cnt}, 64'd0);

        for (int i = 0; i < 17; i++) begin
            n_errh = 0; n_errv = 0; n_fs = 0;
            run_lines(0, tbl[i].lines - 1, tbl[i].short_line, tbl[i].rgb);
            check($sformatf("f%0d_err_hlen", i), n_errh, tbl[i].errh);
            check($sformatf("f%0d_err_vlen", i), n_errv, tbl[i].errv);
            check($sformatf("f%0d_frame_start", i), n_fs, 1);
            check($sformatf("f%0d_locked", i), locked, tbl[i].lock);
            check($sformatf("f%0d_frame_count", i), frame_count, tbl[i].fc);
            check($sformatf("f%0d_hist", i), {red_cnt, grn_cnt, blu_cnt},
                  HIST_ON ? {19'(tbl[i].red), 19'(tbl[i].grn), 19'(tbl[i].blu)} : 57'd0);
        end

        for (int k = 0; k < 6; k++) begin
            check($sformatf("cap%0d_x", k), got_x[k], exp_x[k]);
            check($sformatf("cap%0d_y", k), got_y[k], exp_y[k]);
            check($sformatf("cap%0d_pixel_valid", k), got_pv[k], exp_pv[k]);
        end

        // Loss of hsync while locked: exactly one err_hlen, lock drops, count kept.
        n_errh = 0; n_errv = 0; n_fs = 0;
        run_lines(0, 2, -1, 3'b000);
        check("stall_pre_locked", locked, 1'b1);
        for (int p = 0; p < 1100; p++)
            pix(HT, 3, 1'b1, 1'b1, 3'b000);
        check("stall_err_hlen", n_errh, 1);
        check("stall_err_vlen", n_errv, 0);
        check("stall_locked", locked, 1'b0);
        check("stall_frame_count", frame_count, 8);

        // Asynchronous reset mid-frame, asserted between clock edges.
        run_lines(4, 5, -1, 3'b111);
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        check("async_reset", {x, y, rgb_out, pixel_valid, frame_start, locked, err_hlen, err_vlen,
                              frame_count, red_cnt, grn_cnt, blu_cnt}, 64'd0);
        #20 reset = 1'b1;

        check("pulse_width", n_wide, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
